// File: rtl/mem_access_unit_if.sv
// Data-memory port between the memory-access stage and the data memory.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access / writeback stage: aligned byte/half/word loads and stores
// over a ready-handshaked port, load extension and registered writeback.
module mem_access_unit (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_RegWrite,
  input  logic              in_wed,
  input  logic [1:0]        in_result_src,
  input  logic [2:0]        in_func3,
  input  logic [31:0]       in_alu_result,
  input  logic [31:0]       in_write_data,
  input  logic [31:0]       in_pc_plus_4,
  input  logic [4:0]        in_a_wr,
  mem_access_unit_if.master dmem,
  output logic              stall,
  output logic              wb_RegWrite,
  output logic [4:0]        wb_a_wr,
  output logic [31:0]       wb_result,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_next;
  logic        is_load, is_store, is_both;
  logic        func3_ok, misaligned, mem_ok, mem_bad;
  logic [31:0] cap_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] wb_mux;

  // Classify the presented instruction as a legal, illegal or non-memory op.
  always_comb begin
    is_load    = (in_result_src == 2'b01) && !in_wed;
    is_store   = in_wed && (in_result_src != 2'b01);
    is_both    = in_wed && (in_result_src == 2'b01);
    func3_ok   = 1'b0;
    if (is_load)
      func3_ok = (in_func3 == 3'b000) || (in_func3 == 3'b001) || (in_func3 == 3'b010) ||
                 (in_func3 == 3'b100) || (in_func3 == 3'b101);
    else if (is_store)
      func3_ok = (in_func3 == 3'b000) || (in_func3 == 3'b001) || (in_func3 == 3'b010);
    misaligned = ((in_func3[1:0] == 2'b01) && in_alu_result[0]) ||
                 ((in_func3[1:0] == 2'b10) && (in_alu_result[1:0] != 2'b00));
    mem_ok     = (is_load || is_store) && func3_ok && !misaligned;
    mem_bad    = (is_load || is_store || is_both) && !mem_ok;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state, request and stall; a DONE always returns to IDLE so the
  // still-presented instruction is never issued twice.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    dmem.req   = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_ok) begin
          stall      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        stall    = 1'b1;
        dmem.req = 1'b1;
        if (dmem.ready) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Store lane steering; address and data follow the frozen upstream inputs.
  always_comb begin
    dmem.addr  = {in_alu_result[31:2], 2'b00};
    dmem.we    = dmem.req && is_store;
    dmem.wdata = in_write_data;
    dmem.wstrb = '0;
    unique case (in_func3[1:0])
      2'b00:   dmem.wdata = {4{in_write_data[7:0]}};
      2'b01:   dmem.wdata = {2{in_write_data[15:0]}};
      default: dmem.wdata = in_write_data;
    endcase
    if (dmem.we) begin
      unique case (in_func3[1:0])
        2'b00:   dmem.wstrb = 4'b0001 << in_alu_result[1:0];
        2'b01:   dmem.wstrb = 4'b0011 << in_alu_result[1:0];
        default: dmem.wstrb = 4'b1111;
      endcase
    end
  end

  // Capture the read word when a load completes.
  always_ff @(posedge clk) begin
    if (rst)
      cap_data <= '0;
    else if ((state == ACCESS) && dmem.ready && is_load)
      cap_data <= dmem.rdata;
  end

  // Lane extraction, extension and writeback selection.
  always_comb begin
    unique case (in_alu_result[1:0])
      2'b00:   ld_byte = cap_data[7:0];
      2'b01:   ld_byte = cap_data[15:8];
      2'b10:   ld_byte = cap_data[23:16];
      default: ld_byte = cap_data[31:24];
    endcase
    ld_half = in_alu_result[1] ? cap_data[31:16] : cap_data[15:0];
    unique case (in_func3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = cap_data;
    endcase
    unique case (in_result_src)
      2'b00:   wb_mux = in_alu_result;
      2'b01:   wb_mux = ld_ext;
      2'b10:   wb_mux = in_pc_plus_4;
      default: wb_mux = '0;
    endcase
  end

  // Writeback register; write enable is forced low while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_RegWrite <= 1'b0;
      wb_a_wr     <= '0;
      wb_result   <= '0;
    end else if (stall) begin
      wb_RegWrite <= 1'b0;
    end else begin
      wb_RegWrite <= in_RegWrite && !mem_bad;
      wb_a_wr     <= in_a_wr;
      wb_result   <= wb_mux;
    end
  end

  // Error pulse for an illegal or misaligned access seen in IDLE.
  always_ff @(posedge clk) begin
    if (rst) mem_err <= 1'b0;
    else     mem_err <= (state == IDLE) && mem_bad;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_RegWrite, in_wed;
  logic [1:0]  in_result_src;
  logic [2:0]  in_func3;
  logic [31:0] in_alu_result, in_write_data, in_pc_plus_4;
  logic [4:0]  in_a_wr;
  logic        stall, wb_RegWrite, mem_err;
  logic [4:0]  wb_a_wr;
  logic [31:0] wb_result;
  int          checks = 0;
  int          errors = 0;

  mem_access_unit_if dmem_bus ();

  mem_access_unit dut (
    .clk           (clk),
    .rst           (rst),
    .in_RegWrite   (in_RegWrite),
    .in_wed        (in_wed),
    .in_result_src (in_result_src),
    .in_func3      (in_func3),
    .in_alu_result (in_alu_result),
    .in_write_data (in_write_data),
    .in_pc_plus_4  (in_pc_plus_4),
    .in_a_wr       (in_a_wr),
    .dmem          (dmem_bus.master),
    .stall         (stall),
    .wb_RegWrite   (wb_RegWrite),
    .wb_a_wr       (wb_a_wr),
    .wb_result     (wb_result),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    in_RegWrite = 1'b0; in_wed = 1'b0; in_result_src = 2'b00; in_func3 = 3'b000;
    in_alu_result = '0; in_write_data = '0; in_pc_plus_4 = '0; in_a_wr = '0;
  endtask

  task automatic present(input logic rw, input logic wed, input logic [1:0] src,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd);
    in_RegWrite = rw; in_wed = wed; in_result_src = src; in_func3 = f3;
    in_alu_result = alu; in_write_data = wd; in_a_wr = rd; in_pc_plus_4 = '0;
  endtask

  initial begin
    rst = 1'b1;
    bubble();
    dmem_bus.ready = 1'b0;
    dmem_bus.rdata = '0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_wb_we",    32'(wb_RegWrite), 32'h0);
    check("rst_wb_a_wr",  32'(wb_a_wr),     32'h0);
    check("rst_wb_res",   wb_result,        32'h0);
    check("rst_mem_err",  32'(mem_err),     32'h0);
    check("rst_req",      32'(dmem_bus.req),   32'h0);
    check("rst_we",       32'(dmem_bus.we),    32'h0);
    check("rst_wstrb",    32'(dmem_bus.wstrb), 32'h0);
    check("rst_stall",    32'(stall),       32'h0);

    // ALU op
    present(1'b1, 1'b0, 2'b00, 3'b000, 32'h1234_5678, '0, 5'd5);
    #1 check("alu_stall", 32'(stall), 32'h0);
    step();
    check("alu_wb_we",   32'(wb_RegWrite), 32'h1);
    check("alu_wb_a_wr", 32'(wb_a_wr),     32'd5);
    check("alu_wb_res",  wb_result,        32'h1234_5678);
    check("alu_stall2",  32'(stall),       32'h0);
    bubble();

    // LB at 0x1003, two wait cycles
    present(1'b1, 1'b0, 2'b01, 3'b000, 32'h0000_1003, '0, 5'd7);
    dmem_bus.rdata = 32'h80FF_0000;
    #1;
    check("lb_c0_stall", 32'(stall), 32'h1);
    check("lb_c0_req",   32'(dmem_bus.req), 32'h0);
    step();
    check("lb_c1_req",   32'(dmem_bus.req), 32'h1);
    check("lb_c1_stall", 32'(stall), 32'h1);
    check("lb_c1_addr",  dmem_bus.addr, 32'h0000_1000);
    check("lb_c1_we",    32'(dmem_bus.we), 32'h0);
    step();
    check("lb_c2_req",   32'(dmem_bus.req), 32'h1);
    check("lb_c2_stall", 32'(stall), 32'h1);
    check("lb_c2_wb_we", 32'(wb_RegWrite), 32'h0);
    step();
    check("lb_c3_stall", 32'(stall), 32'h1);
    dmem_bus.ready = 1'b1;
    step();
    dmem_bus.ready = 1'b0;
    check("lb_c4_req",   32'(dmem_bus.req), 32'h0);
    check("lb_c4_stall", 32'(stall), 32'h0);
    step();
    check("lb_wb_we",    32'(wb_RegWrite), 32'h1);
    check("lb_wb_a_wr",  32'(wb_a_wr), 32'd7);
    check("lb_wb_res",   wb_result, 32'hFFFF_FF80);

    // LBU, ready already high in IDLE (must be ignored there)
    present(1'b1, 1'b0, 2'b01, 3'b100, 32'h0000_1003, '0, 5'd8);
    dmem_bus.ready = 1'b1;
    #1 check("lbu_c0_stall", 32'(stall), 32'h1);
    step();
    check("lbu_c1_req", 32'(dmem_bus.req), 32'h1);
    step();
    check("lbu_c2_req", 32'(dmem_bus.req), 32'h0);
    dmem_bus.ready = 1'b0;
    step();
    check("lbu_wb_res", wb_result, 32'h0000_0080);
    check("lbu_wb_we",  32'(wb_RegWrite), 32'h1);

    // SH at 0x2002
    present(1'b0, 1'b1, 2'b00, 3'b001, 32'h0000_2002, 32'hABCD_BEEF, 5'd0);
    #1 check("sh_c0_stall", 32'(stall), 32'h1);
    step();
    check("sh_req",   32'(dmem_bus.req), 32'h1);
    check("sh_we",    32'(dmem_bus.we), 32'h1);
    check("sh_wstrb", 32'(dmem_bus.wstrb), 32'h0000_000C);
    check("sh_wdata", dmem_bus.wdata, 32'hBEEF_BEEF);
    check("sh_addr",  dmem_bus.addr, 32'h0000_2000);
    dmem_bus.ready = 1'b1;
    step();
    dmem_bus.ready = 1'b0;
    step();
    check("sh_wb_we", 32'(wb_RegWrite), 32'h0);
    bubble();

    // Misaligned LW
    present(1'b1, 1'b0, 2'b01, 3'b010, 32'h0000_3001, '0, 5'd9);
    #1;
    check("lwm_stall", 32'(stall), 32'h0);
    check("lwm_req",   32'(dmem_bus.req), 32'h0);
    step();
    check("lwm_err",   32'(mem_err), 32'h1);
    check("lwm_wb_we", 32'(wb_RegWrite), 32'h0);
    check("lwm_req1",  32'(dmem_bus.req), 32'h0);
    bubble();
    step();
    check("lwm_err_clr", 32'(mem_err), 32'h0);

    // Illegal func3 load
    present(1'b1, 1'b0, 2'b01, 3'b011, 32'h0000_3000, '0, 5'd9);
    #1 check("f3_stall", 32'(stall), 32'h0);
    step();
    check("f3_err",   32'(mem_err), 32'h1);
    check("f3_wb_we", 32'(wb_RegWrite), 32'h0);
    check("f3_req",   32'(dmem_bus.req), 32'h0);
    bubble();
    step();
    check("f3_err_clr", 32'(mem_err), 32'h0);

    // JAL link, then SW, then LW back to back
    present(1'b1, 1'b0, 2'b10, 3'b000, 32'h0000_0000, '0, 5'd1);
    in_pc_plus_4 = 32'h0000_0104;
    step();
    check("jal_wb_res", wb_result, 32'h0000_0104);
    check("jal_wb_we",  32'(wb_RegWrite), 32'h1);
    present(1'b0, 1'b1, 2'b00, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 5'd0);
    #1 check("sw_c0_stall", 32'(stall), 32'h1);
    step();
    check("sw_req",   32'(dmem_bus.req), 32'h1);
    check("sw_wstrb", 32'(dmem_bus.wstrb), 32'h0000_000F);
    check("sw_wdata", dmem_bus.wdata, 32'hDEAD_BEEF);
    dmem_bus.ready = 1'b1;
    step();
    dmem_bus.ready = 1'b0;
    check("sw_done_req", 32'(dmem_bus.req), 32'h0);
    step();
    present(1'b1, 1'b0, 2'b01, 3'b010, 32'h0000_4004, '0, 5'd3);
    #1;
    check("lw2_idle_req", 32'(dmem_bus.req), 32'h0);
    check("lw2_stall",    32'(stall), 32'h1);
    step();
    check("lw2_req",  32'(dmem_bus.req), 32'h1);
    check("lw2_addr", dmem_bus.addr, 32'h0000_4004);
    check("lw2_we",   32'(dmem_bus.we), 32'h0);
    dmem_bus.ready = 1'b1;
    dmem_bus.rdata = 32'hCAFE_F00D;
    step();
    dmem_bus.ready = 1'b0;
    check("lw2_done_req", 32'(dmem_bus.req), 32'h0);
    step();
    check("lw2_wb_res",  wb_result, 32'hCAFE_F00D);
    check("lw2_wb_a_wr", 32'(wb_a_wr), 32'd3);
    bubble();

    // Reset while an access is outstanding
    present(1'b1, 1'b0, 2'b01, 3'b010, 32'h0000_5000, '0, 5'd4);
    step();
    check("rsta_req", 32'(dmem_bus.req), 32'h1);
    rst = 1'b1;
    bubble();
    step();
    rst = 1'b0;
    #1;
    check("rsta_req_low", 32'(dmem_bus.req), 32'h0);
    check("rsta_stall",   32'(stall), 32'h0);
    check("rsta_wb_we",   32'(wb_RegWrite), 32'h0);
    step();
    check("rsta_req_idle", 32'(dmem_bus.req), 32'h0);
    check("rsta_wb_we2",   32'(wb_RegWrite), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
